// File: rtl/ram_pkg.sv
// Shared constants and word/address types for the single-port async-read RAM.
package ram_pkg;

  localparam int unsigned RAM_ADDR_SIZE_DEF = 4;
  localparam int unsigned RAM_DATA_SIZE_DEF = 32;

  // Default-sized address and data word types.
  typedef logic [RAM_ADDR_SIZE_DEF-1:0] ram_addr_t;
  typedef logic [RAM_DATA_SIZE_DEF-1:0] ram_word_t;

endpackage : ram_pkg

// File: rtl/ram_array.sv
// Storage array: synchronous clear, synchronous write, combinational read.
// Ports:
//   clk      - clock, all updates on rising edge
//   rst      - synchronous active-high clear of every location (beats we)
//   we       - write enable
//   addr     - shared read/write address
//   wr_data  - write data
//   rd_data  - combinational read of mem[addr]
module ram_array
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = RAM_ADDR_SIZE_DEF,
  parameter int unsigned DATA_SIZE = RAM_DATA_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  output logic [DATA_SIZE-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_SIZE;

  logic [DATA_SIZE-1:0] r_mem [DEPTH];

  // Reset clears the whole array and takes priority over a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[addr] <= wr_data;
    end
  end

  // Read port is a plain mux on the address, no clock involved.
  assign rd_data = r_mem[addr];

endmodule : ram_array

// File: rtl/ram_1port_asyncread.sv
// Single-port RAM: synchronous write, asynchronous read, shared address bus.
// Optional build macro: RAM_WRITE_THROUGH_EN -- while writing (rd_wrb=0, rst=0)
// rd_data shows wr_data combinationally; during rst it shows 0.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high clear of the array
//   addr     - shared read/write address
//   wr_data  - write data
//   rd_wrb   - 1 = read, 0 = write
//   rd_data  - combinational read data
module ram_1port_asyncread
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = $bits(ram_addr_t),
  parameter int unsigned DATA_SIZE = $bits(ram_word_t)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_wrb,
  output logic [DATA_SIZE-1:0] rd_data
);

  logic                 w_we;
  logic [DATA_SIZE-1:0] w_mem_rd;

  // Write is active-low on the shared select.
  assign w_we = ~rd_wrb;

  ram_array #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_SIZE (DATA_SIZE)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (w_we),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (w_mem_rd)
  );

`ifdef RAM_WRITE_THROUGH_EN
  // Bypass the incoming write data so the written value is visible before the edge.
  always_comb begin
    rd_data = w_mem_rd;
    if (rst) begin
      rd_data = '0;
    end else if (w_we) begin
      rd_data = wr_data;
    end
  end
`else
  assign rd_data = w_mem_rd;
`endif

endmodule : ram_1port_asyncread

// File: tb/tb_ram_1port_asyncread.sv
module tb_ram_1port_asyncread;
  import ram_pkg::*;

  localparam int unsigned AW    = RAM_ADDR_SIZE_DEF;
  localparam int unsigned DW    = RAM_DATA_SIZE_DEF;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic          rd_wrb;
  logic [DW-1:0] rd_data;

  int checks;
  int failures;

  // Bench-side reference contents and scoreboard of pending expectations.
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] sb_q [$];

  ram_1port_asyncread #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_wrb  (rd_wrb),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write one word on the next rising edge and mirror it in the model.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    addr = a; wr_data = d; rd_wrb = 1'b0;
    @(posedge clk);
    #1;
    rd_wrb = 1'b1;
    model[a] = d;
  endtask

  // Present a read address between edges and push the expected word.
  task automatic set_read(input logic [AW-1:0] a);
    rd_wrb = 1'b1;
    addr   = a;
    sb_q.push_back(model[a]);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] exp_v;
    rst = 1'b1; rd_wrb = 1'b1; addr = '0; wr_data = '0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < int'(DEPTH); i++) begin
      set_read(AW'(i));
      exp_v = sb_q.pop_front();
      checks++;
      if (rd_data !== exp_v) begin
        failures++;
        $display("FAIL reset_clear addr=%0d got=%h exp=%h", i, rd_data, exp_v);
      end
    end
  endtask

  task automatic test_write_readback();
    logic [DW-1:0] exp_v;
    do_write(AW'(0), 32'h8008_8008);
    do_write(AW'(1), 32'h4004_4004);
    do_write(AW'(2), 32'h2002_2002);
    do_write(AW'(3), 32'h1001_1001);
    @(negedge clk);
    for (int i = 0; i < int'(DEPTH); i++) begin
      set_read(AW'(i));
      exp_v = sb_q.pop_front();
      checks++;
      if (rd_data !== exp_v) begin
        failures++;
        $display("FAIL write_readback addr=%0d got=%h exp=%h", i, rd_data, exp_v);
      end
    end
  endtask

  task automatic test_async_read();
    logic [DW-1:0] exp_v;
    time t0;
    @(negedge clk);
    t0 = $time;
    set_read(AW'(0));
    exp_v = sb_q.pop_front();
    checks++;
    if (rd_data !== exp_v) begin
      failures++;
      $display("FAIL async_read_a0 got=%h exp=%h", rd_data, exp_v);
    end
    set_read(AW'(3));
    exp_v = sb_q.pop_front();
    checks++;
    if (rd_data !== exp_v || ($time - t0) >= 5) begin
      failures++;
      $display("FAIL async_read_a3 got=%h exp=%h dt=%0t", rd_data, exp_v, $time - t0);
    end
  endtask

  task automatic test_read_no_write();
    logic [DW-1:0] exp_v;
    @(negedge clk);
    rd_wrb = 1'b1; addr = AW'(2); wr_data = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    set_read(AW'(2));
    exp_v = sb_q.pop_front();
    checks++;
    if (rd_data !== exp_v) begin
      failures++;
      $display("FAIL read_no_write got=%h exp=%h", rd_data, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_v;
    for (int i = 0; i < int'(DEPTH); i++) do_write(AW'(i), $urandom());
    @(negedge clk);
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      set_read(AW'(i));
      exp_v = sb_q.pop_front();
      checks++;
      if (rd_data !== exp_v) begin
        failures++;
        $display("FAIL back_to_back addr=%0d got=%h exp=%h", i, rd_data, exp_v);
      end
    end
  endtask

  task automatic test_reset_priority();
    logic [DW-1:0] exp_v;
    do_write(AW'(0), 32'h8008_8008);
    do_write(AW'(1), 32'h4004_4004);
    do_write(AW'(2), 32'h2002_2002);
    do_write(AW'(3), 32'h1001_1001);
    do_write(AW'(5), 32'h0F0F_0F0F);
    @(negedge clk);
    rst = 1'b1; rd_wrb = 1'b0; addr = AW'(5); wr_data = 32'h1234_5678;
    @(posedge clk); #1;
    clear_model();
`ifdef RAM_WRITE_THROUGH_EN
    checks++;
    if (rd_data !== '0) begin
      failures++;
      $display("FAIL reset_bypass_zero got=%h exp=%h", rd_data, 32'h0);
    end
`endif
    @(negedge clk);
    rst = 1'b0; rd_wrb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_read(AW'(i));
      exp_v = sb_q.pop_front();
      checks++;
      if (rd_data !== exp_v) begin
        failures++;
        $display("FAIL reset_priority addr=%0d got=%h exp=%h", i, rd_data, exp_v);
      end
    end
  endtask

  task automatic test_overwrite();
    logic [DW-1:0] exp_v;
    do_write(AW'(7), 32'hAAAA_AAAA);
    @(negedge clk);
    addr = AW'(7); wr_data = 32'h5555_5555; rd_wrb = 1'b0;
`ifdef RAM_WRITE_THROUGH_EN
    sb_q.push_back(32'h5555_5555);
`else
    sb_q.push_back(32'hAAAA_AAAA);
`endif
    #1;
    exp_v = sb_q.pop_front();
    checks++;
    if (rd_data !== exp_v) begin
      failures++;
      $display("FAIL overwrite_pre_edge got=%h exp=%h", rd_data, exp_v);
    end
    @(posedge clk); #1;
    rd_wrb = 1'b1;
    model[7] = 32'h5555_5555;
    @(negedge clk);
    set_read(AW'(7));
    exp_v = sb_q.pop_front();
    checks++;
    if (rd_data !== exp_v) begin
      failures++;
      $display("FAIL overwrite_final got=%h exp=%h", rd_data, exp_v);
    end
    set_read(AW'(6));
    exp_v = sb_q.pop_front();
    checks++;
    if (rd_data !== exp_v) begin
      failures++;
      $display("FAIL overwrite_neighbour got=%h exp=%h", rd_data, exp_v);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; rd_wrb = 1'b1; addr = '0; wr_data = '0;
    test_reset();
    test_write_readback();
    test_async_read();
    test_read_no_write();
    test_reset_priority();
    test_back_to_back();
    test_overwrite();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule : tb_ram_1port_asyncread
